// File: rtl/sync_fifo_ext_if.sv
// Handshake bundle for sync_fifo_ext: write request/data in, read request in, read data/valid out.
// The master side drives the requests; the FIFO is the slave.
interface sync_fifo_ext_if #(
  parameter int BITWID = 8
);
  logic              wr_en;
  logic [BITWID-1:0] wr_data;
  logic              rd_en;
  logic [BITWID-1:0] rd_data;
  logic              rd_data_vld;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_data_vld
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_data_vld
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with programmable almost-full/almost-empty levels, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; the default build is registered-read.
module sync_fifo_ext #(
  parameter int DEEPWID = 3,
  parameter int BITWID  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               err_clr,
  sync_fifo_ext_if.slave     bus,
  input  logic [DEEPWID:0]   cfg_almost_full,
  input  logic [DEEPWID:0]   cfg_almost_empty,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [DEEPWID:0]   fifo_num,
  output logic               overflow,
  output logic               underflow
);

  localparam int               DEPTH_INT = 1 << DEEPWID;
  localparam logic [DEEPWID:0] DEPTH     = (DEEPWID+1)'(DEPTH_INT);

  logic [BITWID-1:0]  mem [DEPTH_INT];
  logic [DEEPWID-1:0] wr_ptr;
  logic [DEEPWID-1:0] rd_ptr;
  logic               wr_acc;
  logic               rd_acc;

  assign full         = (fifo_num == DEPTH);
  assign empty        = (fifo_num == '0);
  assign almost_full  = (fifo_num >= cfg_almost_full);
  assign almost_empty = (fifo_num <= cfg_almost_empty);

  // Acceptance is judged on the flags at the start of the cycle, so a write
  // into a full FIFO is dropped even when a read frees a slot the same cycle.
  assign wr_acc = bus.wr_en && !full  && !flush;
  assign rd_acc = bus.rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_num <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + DEEPWID'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + DEEPWID'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_num <= fifo_num + (DEEPWID+1)'(1);
        2'b01:   fifo_num <= fifo_num - (DEEPWID+1)'(1);
        default: fifo_num <= fifo_num;
      endcase
    end
  end

  // A fresh error event outranks err_clr, so the flag survives a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (bus.wr_en && full  && !flush) || (overflow  && !err_clr);
      underflow <= (bus.rd_en && empty && !flush) || (underflow && !err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data_vld = !empty;
  assign bus.rd_data     = empty ? '0 : mem[rd_ptr];
`else
  logic [BITWID-1:0] rd_data_q;
  logic              rd_data_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      rd_data_vld_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.rd_data_vld = rd_data_vld_q;
  assign bus.rd_data     = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench for sync_fifo_ext: a queue-based model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_sync_fifo_ext;

  localparam int DW = 3;
  localparam int BW = 8;
  localparam int D  = 8;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic          flush   = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW:0]   cfg_af  = 4'd6;
  logic [DW:0]   cfg_ae  = 4'd1;
  logic          full;
  logic          empty;
  logic          af;
  logic          ae;
  logic          ovf;
  logic          unf;
  logic [DW:0]   fifo_num;

  sync_fifo_ext_if #(.BITWID(BW)) bus ();

  sync_fifo_ext #(.DEEPWID(DW), .BITWID(BW)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .err_clr          (err_clr),
    .bus              (bus.slave),
    .cfg_almost_full  (cfg_af),
    .cfg_almost_empty (cfg_ae),
    .full             (full),
    .empty            (empty),
    .almost_full      (af),
    .almost_empty     (ae),
    .fifo_num         (fifo_num),
    .overflow         (ovf),
    .underflow        (unf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] q[$];
  logic          m_vld    = 1'b0;
  logic [BW-1:0] m_data   = '0;
  logic          m_ovf    = 1'b0;
  logic          m_unf    = 1'b0;
  bit            model_ok = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [BW-1:0] wd,
                               input logic rd, input logic fl, input logic ec);
    rst         = r;
    bus.wr_en   = w;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    flush       = fl;
    err_clr     = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_fifo_num"}, fifo_num, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_rd_data"}, bus.rd_data, 0);
    checkOutput({tag, "_rd_data_vld"}, bus.rd_data_vld, 0);
    checkOutput({tag, "_overflow"}, ovf, 0);
    checkOutput({tag, "_underflow"}, unf, 0);
    checkOutput({tag, "_almost_empty"}, ae, 1);
    checkOutput({tag, "_almost_full"}, af, 0);
  endtask

  // Reference behaviour: a plain queue updated from the inputs seen at each rising edge.
  always @(posedge clk) begin : model
    bit was_full;
    bit was_empty;
    if (rst) begin
      q.delete();
      m_vld    = 1'b0;
      m_data   = '0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      m_ovf = (bus.wr_en && was_full  && !flush) || (m_ovf && !err_clr);
      m_unf = (bus.rd_en && was_empty && !flush) || (m_unf && !err_clr);
      m_vld = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (bus.rd_en && !was_empty) begin
          m_data = q.pop_front();
          m_vld  = 1'b1;
        end
        if (bus.wr_en && !was_full) begin
          q.push_back(bus.wr_data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("cyc_fifo_num", fifo_num, q.size());
      checkOutput("cyc_full", full, q.size() == D);
      checkOutput("cyc_empty", empty, q.size() == 0);
      checkOutput("cyc_almost_full", af, q.size() >= int'(cfg_af));
      checkOutput("cyc_almost_empty", ae, q.size() <= int'(cfg_ae));
      checkOutput("cyc_overflow", ovf, m_ovf);
      checkOutput("cyc_underflow", unf, m_unf);
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("cyc_rd_data_vld", bus.rd_data_vld, q.size() != 0);
      if (q.size() != 0) begin
        checkOutput("cyc_rd_data", bus.rd_data, q[0]);
      end
`else
      checkOutput("cyc_rd_data_vld", bus.rd_data_vld, m_vld);
      checkOutput("cyc_rd_data", bus.rd_data, m_data);
`endif
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    rst         = 1'b1;
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    checkResetState("reset");

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, 8'(i), 0, 0, 0);
      checkOutput("fill_count", fifo_num, i);
      checkOutput("fill_almost_full", af, (i >= 6) ? 1 : 0);
    end
    checkOutput("fill_full", full, 1);

    applyStimulus(0, 1, 8'hFF, 0, 0, 0);
    checkOutput("ovf_flag", ovf, 1);
    checkOutput("ovf_count", fifo_num, 8);

    for (int i = 1; i <= 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("drain_head", bus.rd_data, i);
      checkOutput("drain_vld", bus.rd_data_vld, 1);
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
`else
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
      checkOutput("drain_data", bus.rd_data, i);
      checkOutput("drain_vld", bus.rd_data_vld, 1);
`endif
    end
    checkOutput("drain_empty", empty, 1);
    applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checkOutput("unf_flag", unf, 1);
    checkOutput("unf_vld", bus.rd_data_vld, 0);

    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("clr_overflow", ovf, 0);
    checkOutput("clr_underflow", unf, 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'(8'h10 + i), 0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("stream_head", bus.rd_data, (i < 5) ? (8'h10 + i) : (8'h20 + i - 5));
      applyStimulus(0, 1, 8'(8'h20 + i), 1, 0, 0);
`else
      applyStimulus(0, 1, 8'(8'h20 + i), 1, 0, 0);
      checkOutput("stream_data", bus.rd_data, (i < 5) ? (8'h10 + i) : (8'h20 + i - 5));
`endif
      checkOutput("stream_count", fifo_num, 5);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 8'h00, 1, 0, 0);
    end
    checkOutput("pre_flush_underflow", unf, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 8'(8'h30 + i), 0, 0, 0);
    end
    applyStimulus(0, 1, 8'h77, 1, 1, 0);
    checkOutput("flush_count", fifo_num, 0);
    checkOutput("flush_empty", empty, 1);
    checkOutput("flush_vld", bus.rd_data_vld, 0);
    checkOutput("flush_underflow", unf, 1);
    checkOutput("flush_overflow", ovf, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 8'(8'h40 + i), 0, 0, 0);
    end
    applyStimulus(0, 1, 8'hEE, 0, 0, 1);
    checkOutput("clr_vs_ovf_overflow", ovf, 1);
    checkOutput("clr_vs_ovf_underflow", unf, 0);
    checkOutput("clr_vs_ovf_count", fifo_num, 8);

    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'(8'h50 + i), 0, 0, 0);
    end
    checkOutput("pre_rst_count", fifo_num, 3);
    applyStimulus(1, 0, 8'h00, 0, 0, 0);
    checkResetState("mid_reset");

    applyStimulus(0, 1, 8'hA5, 0, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("fwft_vld", bus.rd_data_vld, 1);
    checkOutput("fwft_data", bus.rd_data, 8'hA5);
    applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checkOutput("fwft_pop_empty", empty, 1);
`else
    checkOutput("post_rst_vld_idle", bus.rd_data_vld, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checkOutput("post_rst_data", bus.rd_data, 8'hA5);
    checkOutput("post_rst_vld", bus.rd_data_vld, 1);
    checkOutput("post_rst_empty", empty, 1);
`endif
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter DEEPWID, default 3, log2 of depth; depth D = 2^DEEPWID.
REQ-002 SHALL have parameter BITWID, default 8, data word width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of contents.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_data  input  BITWID  write word.
REQ-009 SHALL have port rd_en  input  1  read request (standard mode) / pop acknowledge (FWFT mode).
REQ-010 SHALL have port rd_data  output  BITWID  read word.
REQ-011 SHALL have port rd_data_vld  output  1  rd_data valid qualifier.
REQ-012 SHALL have port cfg_almost_full  input  DEEPWID+1  almost-full threshold.
REQ-013 SHALL have port cfg_almost_empty  input  DEEPWID+1  almost-empty threshold.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port fifo_num  output  DEEPWID+1  stored word count, 0..D.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-017 SHALL have port err_clr  input  1  clears overflow/underflow.

Function
REQ-018 Write accepted iff wr_en && !full && !flush; word stored at write pointer; pointer advances, wraps D-1 -> 0.
REQ-019 Read accepted iff rd_en && !empty && !flush; read pointer advances, wraps D-1 -> 0.
REQ-020 Acceptance uses flags at cycle start; write when full is dropped even if a read is accepted the same cycle.
REQ-021 fifo_num registered: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds D or goes below 0.
REQ-022 full = (fifo_num == D); empty = (fifo_num == 0); both derived from registered count, no extra latency.
REQ-023 almost_full = (fifo_num >= cfg_almost_full); almost_empty = (fifo_num <= cfg_almost_empty); unsigned DEEPWID+1-bit compare.
REQ-024 wr_en while full (and !flush) sets overflow next cycle; word discarded, contents unchanged.
REQ-025 rd_en while empty (and !flush) sets underflow next cycle; rd_data_vld stays low, rd_data unchanged.
REQ-026 err_clr clears overflow/underflow next cycle; a new error event in the same cycle wins (flag stays 1).
REQ-027 flush clears pointers and fifo_num to 0 next cycle, overrides wr_en/rd_en that cycle, drops rd_data_vld; overflow/underflow unaffected.
REQ-028 Data ordering strictly first-in first-out across wrap-around; no word duplicated or lost except dropped overflow writes.

Reset
REQ-029 rst sampled on clk rising edge; takes priority over flush, err_clr, wr_en, rd_en.
REQ-030 After reset: pointers 0, fifo_num 0, empty 1, full 0, rd_data 0, rd_data_vld 0, overflow 0, underflow 0; almost_* per REQ-023 with count 0.
REQ-031 Reset asserted mid-operation discards all stored words; storage array contents need not be cleared.

Configuration
REQ-032 Macro SYNC_FIFO_FWFT_EN selects read mode.
REQ-033 Without SYNC_FIFO_FWFT_EN: standard mode; accepted read at cycle N drives rd_data with head word and rd_data_vld=1 at cycle N+1 for one cycle; rd_data holds last value otherwise.
REQ-034 With SYNC_FIFO_FWFT_EN: first-word fall-through; rd_data_vld = !empty, rd_data = head word combinationally whenever rd_data_vld=1; write into empty FIFO at cycle N visible at N+1; rd_en with rd_data_vld=1 pops head, next word (if any) presented following cycle.
REQ-035 Flags, counts, errors, flush identical in both modes.

Verification (DEEPWID=3, BITWID=8, cfg_almost_full=6, cfg_almost_empty=1)
REQ-036 Write 0x01..0x08 back-to-back -> full=1 after 8th, fifo_num=8, almost_full=1 from count 6; 9th write 0xFF -> overflow=1, fifo_num stays 8.
REQ-037 Drain 8 reads (standard) -> rd_data 0x01..0x08 each one cycle after rd_en with rd_data_vld=1; empty=1; 9th read -> underflow=1, rd_data_vld=0.
REQ-038 Fill 5, then 20 cycles simultaneous wr/rd -> fifo_num constant 5, ordered data across pointer wrap.
REQ-039 Fill 4, assert flush with wr_en=rd_en=1 -> next cycle fifo_num=0, empty=1, no data out, overflow/underflow unchanged; err_clr with wr_en to full same cycle -> overflow stays 1.
REQ-040 FWFT build: write 0xA5 into empty -> next cycle rd_data_vld=1, rd_data=0xA5 without rd_en; rd_en pops, empty=1 next cycle.
REQ-041 Fill 3, assert rst -> next cycle all outputs at REQ-030 values; subsequent write/read returns new data only.
